// File: rtl/stopwatch_ctrl_if.sv
// Command/status bundle between the stopwatch front-end and its surroundings:
// raw buttons and timer expiry in, timer commands and indicators out.
interface stopwatch_ctrl_if;
    logic       btn_mode;
    logic       btn_add;
    logic       btn_clear;
    logic       time_up;
    logic       enable_in;
    logic       lap;
    logic       enable_dec;
    logic       clock_div;
    logic       clear;
    logic       alarm;
    logic [2:0] state_o;

    modport master (
        output btn_mode, btn_add, btn_clear, time_up,
        input  enable_in, lap, enable_dec, clock_div, clear, alarm, state_o
    );

    modport slave (
        input  btn_mode, btn_add, btn_clear, time_up,
        output enable_in, lap, enable_dec, clock_div, clear, alarm, state_o
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Button conditioning plus IDLE/SET/RUN/PAUSE/DONE mode FSM that drives the
// countdown timer's command strobes and a blinking expiry alarm.
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 10_000_000,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             nrst,
    stopwatch_ctrl_if.slave  bus
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Button vectors are ordered {clear, add, mode}.
    logic [2:0]          w_raw;
    logic [2:0]          r_sync1;
    logic [2:0]          r_sync2;
    logic [2:0]          r_lvl;
    logic [2:0]          r_lvl_d;
    logic [2:0][DW-1:0]  r_dbcnt;
    logic [2:0]          w_press;
    logic                w_clr;
    logic                w_mode;
    logic                w_add;
    logic                w_go_idle;

    state_t              r_state;
    logic [TW-1:0]       r_tick;
    logic [TW-1:0]       w_tick_next;
    logic                w_tick_wrap;
    logic                r_enable_in;
    logic                r_enable_dec;
    logic                r_lap;
    logic                r_clock_div;
    logic                r_clear;
    logic                r_alarm;

    assign w_raw = {bus.btn_clear, bus.btn_add, bus.btn_mode};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_lvl   <= '0;
            r_lvl_d <= '0;
            r_dbcnt <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_lvl_d <= r_lvl;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_lvl[i]) begin
                    r_dbcnt[i] <= '0;
                end else if (r_dbcnt[i] == DB_LAST) begin
                    r_lvl[i]   <= r_sync2[i];
                    r_dbcnt[i] <= '0;
                end else begin
                    r_dbcnt[i] <= r_dbcnt[i] + DW'(1);
                end
            end
        end
    end

    // Only debounced rising edges count; the lower-priority presses are masked.
    assign w_press   = r_lvl & ~r_lvl_d;
    assign w_clr     = w_press[2];
    assign w_mode    = w_press[0] & ~w_press[2];
    assign w_add     = w_press[1] & ~w_press[0] & ~w_press[2];
    assign w_go_idle = w_clr | ((r_state == S_DONE) & w_mode);

    assign w_tick_wrap = (r_tick == TICK_LAST);
    assign w_tick_next = w_tick_wrap ? '0 : r_tick + TW'(1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= S_IDLE;
            r_tick       <= '0;
            r_enable_in  <= 1'b0;
            r_enable_dec <= 1'b0;
            r_lap        <= 1'b0;
            r_clock_div  <= 1'b0;
            r_clear      <= 1'b0;
            r_alarm      <= 1'b0;
        end else begin
            r_lap       <= 1'b0;
            r_clock_div <= 1'b0;
            r_clear     <= 1'b0;
            if (w_go_idle) begin
                r_state      <= S_IDLE;
                r_clear      <= 1'b1;
                r_enable_in  <= 1'b0;
                r_enable_dec <= 1'b0;
                r_alarm      <= 1'b0;
                r_tick       <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_mode) begin
                            r_state     <= S_SET;
                            r_enable_in <= 1'b1;
                        end
                    end
                    S_SET: begin
                        if (w_mode) begin
                            r_state      <= S_RUN;
                            r_enable_in  <= 1'b0;
                            r_enable_dec <= 1'b1;
                            r_tick       <= '0;
                        end else if (w_add) begin
                            r_lap <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (bus.time_up) begin
                            r_state      <= S_DONE;
                            r_enable_dec <= 1'b0;
                            r_alarm      <= 1'b1;
                            r_tick       <= '0;
                        end else begin
                            // The exit cycle into PAUSE still counts, so the resumed fraction stays exact.
                            r_tick <= w_tick_next;
                            if (w_mode) begin
                                r_state      <= S_PAUSE;
                                r_enable_dec <= 1'b0;
                            end else begin
                                r_clock_div <= w_tick_wrap;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (w_mode) begin
                            r_state      <= S_RUN;
                            r_enable_dec <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_tick <= w_tick_next;
                        if (w_tick_wrap) begin
                            r_alarm <= ~r_alarm;
                        end
                    end
                    default: begin
                        r_state      <= S_IDLE;
                        r_enable_in  <= 1'b0;
                        r_enable_dec <= 1'b0;
                        r_alarm      <= 1'b0;
                        r_tick       <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.enable_in  = r_enable_in;
    assign bus.enable_dec = r_enable_dec;
    assign bus.lap        = r_lap;
    assign bus.clock_div  = r_clock_div;
    assign bus.clear      = r_clear;
    assign bus.alarm      = r_alarm;
    assign bus.state_o    = r_state;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Front-end controller that drives the countdown timer's command interface from three raw push-buttons and consumes its `time_up` flag. It conditions the buttons (synchronize, debounce, edge-detect) and runs a mode FSM (IDLE/SET/RUN/PAUSE/DONE). It generates `enable_in`, `lap`, `enable_dec`, `clock_div` and `clear` with the exact pulse discipline the timer requires, and raises a blinking alarm on expiry. It sits between the board buttons and the timer instance.

## Interface
- `TICK_DIV`, default 10_000_000: clk cycles per count-down tick (1 Hz at 10 MHz); ≥ 2
- `DB_CYCLES`, default 4: consecutive stable synchronized samples needed to accept a button level change; ≥ 1
- `clk`  in  1  system clock, all logic on rising edge
- `nrst`  in  1  asynchronous, active-low reset
- `btn_mode`  in  1  raw button, active-high: start/pause/resume/arm
- `btn_add`  in  1  raw button: add 30 s while in SET
- `btn_clear`  in  1  raw button: abort/clear
- `time_up`  in  1  timer expiry flag, sticky until timer `clear`
- `enable_in`  out  1  timer load mode (high in SET)
- `lap`  out  1  one-cycle strobe: timer adds 30
- `enable_dec`  out  1  timer count-down mode (high in RUN)
- `clock_div`  out  1  one-cycle decrement strobe per tick, RUN only
- `clear`  out  1  one-cycle timer clear strobe
- `alarm`  out  1  expiry indicator, blinks in DONE
- `state_o`  out  3  FSM state: IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4

## Operation
- **Button path (per button)**
  - 2-flop synchronizer.
  - Debounce counter: increments each cycle the sync output differs from the debounced level; resets to 0 when they match.
  - On the DB_CYCLES-th consecutive differing cycle, the debounced level takes the new value and the counter returns to 0.
  - Press = debounced rising edge (`level & ~level_d`). Releases produce no event.
- **Press priority within one cycle:** clear > mode > add. Lower-priority presses in the same cycle are dropped.
- **IDLE:** all enables low.
  - mode → SET.
  - clear → stay IDLE, pulse `clear`.
- **SET:** `enable_in`=1.
  - add → `lap`=1 for exactly one cycle, stay SET.
  - mode → RUN; tick counter := 0.
  - clear → IDLE plus `clear` pulse.
- **RUN:** `enable_dec`=1. The tick counter (width clog2(TICK_DIV)) counts 0..TICK_DIV-1 and wraps. `clock_div`=1 for the cycle after the counter equals TICK_DIV-1.
  - time_up=1 → DONE.
  - mode → PAUSE.
  - clear → IDLE plus `clear` pulse.
  - Same-cycle conflicts: clear beats time_up; time_up beats mode.
- **PAUSE:** enables low. The tick counter holds, so the resumed fraction is preserved.
  - mode → RUN without resetting the counter.
  - clear → IDLE plus `clear` pulse.
- **DONE:** enables low.
  - `alarm`=1 on entry. The tick counter restarts at 0 and `alarm` toggles at each wrap.
  - mode or clear press → IDLE plus `clear` pulse (which deasserts `time_up`). `alarm` returns to 0.
- **Clear discipline:** in any cycle with `clear`=1, `enable_in`=`enable_dec`=`lap`=`clock_div`=0. The timer honours `clear` only when both enables are low.
- **Strobe discipline:**
  - `lap` is never high in two consecutive cycles.
  - `lap` and `clock_div` are never high simultaneously.
- **Tick counter:** cleared to 0 on every entry to IDLE.
- **Outputs:** all registered; no combinational path from inputs to outputs.

## Timing
- **Reset (`nrst`=0, asynchronous):**
  - `state_o`=IDLE; all outputs 0.
  - Synchronizers, debounced levels and edge history at 0; all counters at 0.
  - Reset mid-RUN drops `enable_dec` immediately. It issues no `clear`; the timer is reset by the same `nrst`.
- **Press latency:**
  - Edge 1 is the first edge that samples a raw level held steady high.
  - The debounced level rises at edge DB_CYCLES+2.
  - FSM state and outputs change at edge DB_CYCLES+3 (edge 7 for DB_CYCLES=4).
- **Glitch rejection:** a raw pulse shorter than DB_CYCLES cycles after synchronization produces no press.
- **Held button:** exactly one press per debounced rise, regardless of hold length.
- **Tick cadence:** the first `clock_div` occurs TICK_DIV cycles after entering RUN from SET; subsequent strobes every TICK_DIV cycles.
- **State/output alignment:** `state_o` and the mode outputs change on the same edge.
- **Pulse width:** `clear` and `lap` are one cycle wide.

## Test plan
Parameters TICK_DIV=10, DB_CYCLES=4.

1. **Reset:** assert `nrst`=0 mid-RUN → `enable_dec`=0 asynchronously, `state_o`=0, all outputs 0.
2. **Bounce rejection:** raw `btn_mode` high for 3 cycles → no state change. Then hold 20 cycles → SET at edge 7, exactly one event.
3. **Load:** in SET, press `btn_add` 3 times (each released in between) → three isolated single-cycle `lap` strobes while `enable_in`=1.
4. **Countdown and expiry:**
   - mode → RUN; `clock_div` pulses every 10 cycles, first pulse 10 cycles after entry.
   - Drive `time_up`=1 → DONE next edge; `alarm` toggles every 10 cycles.
   - Press mode → IDLE with a one-cycle `clear` and both enables 0 in that cycle.
5. **Pause/resume:**
   - In RUN, press mode 4 cycles after a tick → PAUSE; no `clock_div` for 50 cycles.
   - mode again → first `clock_div` 6 cycles after re-entering RUN.
6. **Simultaneous events:**
   - In RUN, clear and mode pressed the same cycle → IDLE plus `clear`.
   - `time_up` and mode press the same cycle → DONE.
